// File: rtl/crtc_cfg_sequencer.sv
// CRTC preset loader and bus arbiter: writes a 50/60 Hz register preset as select/data pairs,
// then restores the CPU's register-select latch. Optional `CRTC_CFG_VSYNC_ALIGN_EN aligns the burst to VSYNC fall.
module crtc_cfg_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int GAP      = 0
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       start,
  input  logic       preset_sel,
  output logic       busy,
  output logic       done,
  input  logic       cpu_req,
  input  logic       cpu_rnw,
  input  logic       cpu_rs,
  input  logic [7:0] cpu_di,
  output logic       cpu_ack,
  input  logic       vsync,
  output logic       crtc_en,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di
);

`ifdef CRTC_CFG_VSYNC_ALIGN_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_DAT, S_GAPWAIT, S_RST, S_FIN, S_WAIT_V
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_DAT, S_GAPWAIT, S_RST, S_FIN
  } state_t;
`endif

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [3:0] GAP_W    = 4'(GAP);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  localparam bit         GAP_ZERO = (GAP_W == 4'd0);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     r_gap_next;
  state_t     w_gap_tgt;
  logic [3:0] r_idx;
  logic [3:0] r_gap_cnt;
  logic [4:0] r_shadow;
  logic       r_pending;
  logic       r_preset;
  logic       w_launch;
  logic       w_shadow_we;
  logic       w_idx_inc;
  logic       w_gap_load;
  logic       w_start_ok;

`ifdef CRTC_CFG_VSYNC_ALIGN_EN
  logic       r_vsync;
`else
  logic       w_unused_vsync;
  assign w_unused_vsync = vsync;
`endif

  function automatic logic [7:0] preset_val(input logic sel, input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'd63;
      4'd1:    return 8'd40;
      4'd2:    return 8'd46;
      4'd3:    return 8'h8E;
      4'd4:    return sel ? 8'd31 : 8'd38;
      4'd6:    return 8'd25;
      4'd7:    return sel ? 8'd28 : 8'd30;
      4'd9:    return 8'd7;
      4'd12:   return 8'h30;
      default: return 8'd0;
    endcase
  endfunction

  // After a sequencer strobe either go straight on or park in the gap counter.
  function automatic state_t step_to(input state_t tgt);
    return GAP_ZERO ? tgt : S_GAPWAIT;
  endfunction

  // State register.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, bus mux and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_tgt   = S_IDLE;
    w_launch    = 1'b0;
    w_shadow_we = 1'b0;
    w_idx_inc   = 1'b0;
    w_gap_load  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    cpu_ack     = 1'b0;
    crtc_en     = 1'b0;
    crtc_ncs    = 1'b1;
    crtc_rnw    = 1'b1;
    crtc_rs     = 1'b0;
    crtc_di     = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          cpu_ack     = 1'b1;
          crtc_en     = 1'b1;
          crtc_ncs    = 1'b0;
          crtc_rnw    = cpu_rnw;
          crtc_rs     = cpu_rs;
          crtc_di     = cpu_di;
          w_shadow_we = !cpu_rnw && !cpu_rs;
        end else if (r_pending || start) begin
          w_launch = 1'b1;
`ifdef CRTC_CFG_VSYNC_ALIGN_EN
          w_state_nxt = S_WAIT_V;
`else
          w_state_nxt = S_SEL;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef CRTC_CFG_VSYNC_ALIGN_EN
      S_WAIT_V: begin
        busy = 1'b1;
        if (r_vsync && !vsync) w_state_nxt = S_SEL;
        else                   w_state_nxt = S_WAIT_V;
      end
`endif
      S_SEL: begin
        busy        = 1'b1;
        crtc_en     = 1'b1;
        crtc_ncs    = 1'b0;
        crtc_rnw    = 1'b0;
        crtc_di     = {4'h0, r_idx};
        w_gap_tgt   = S_DAT;
        w_gap_load  = !GAP_ZERO;
        w_state_nxt = step_to(S_DAT);
      end
      S_DAT: begin
        busy       = 1'b1;
        crtc_en    = 1'b1;
        crtc_ncs   = 1'b0;
        crtc_rnw   = 1'b0;
        crtc_rs    = 1'b1;
        crtc_di    = preset_val(r_preset, r_idx);
        w_gap_load = !GAP_ZERO;
        if (r_idx == LAST_IDX) begin
          w_gap_tgt = S_RST;
        end else begin
          w_gap_tgt = S_SEL;
          w_idx_inc = 1'b1;
        end
        w_state_nxt = step_to(w_gap_tgt);
      end
      S_GAPWAIT: begin
        busy = 1'b1;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = r_gap_next;
        else                       w_state_nxt = S_GAPWAIT;
      end
      S_RST: begin
        busy        = 1'b1;
        crtc_en     = 1'b1;
        crtc_ncs    = 1'b0;
        crtc_rnw    = 1'b0;
        crtc_di     = {3'b000, r_shadow};
        w_gap_tgt   = S_FIN;
        w_gap_load  = !GAP_ZERO;
        w_state_nxt = step_to(S_FIN);
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef CRTC_CFG_VSYNC_ALIGN_EN
  assign w_start_ok = (r_state == S_IDLE) || (r_state == S_WAIT_V);
`else
  assign w_start_ok = (r_state == S_IDLE);
`endif

  // Sequencer datapath: shadowed address, pending request, preset choice, index and gap counter.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_shadow   <= 5'd0;
      r_pending  <= 1'b0;
      r_preset   <= 1'b0;
      r_idx      <= 4'd0;
      r_gap_cnt  <= 4'd0;
      r_gap_next <= S_IDLE;
`ifdef CRTC_CFG_VSYNC_ALIGN_EN
      r_vsync    <= 1'b0;
`endif
    end else begin
      if (w_shadow_we) r_shadow <= cpu_di[4:0];
      if (start && w_start_ok) r_preset <= preset_sel;
      // A start that loses to a CPU access is remembered for the next idle cycle.
      if (w_launch)                                  r_pending <= 1'b0;
      else if (start && cpu_req && r_state == S_IDLE) r_pending <= 1'b1;
      if (r_state == S_FIN) r_idx <= 4'd0;
      else if (w_idx_inc)   r_idx <= r_idx + 4'd1;
      if (w_gap_load) begin
        r_gap_cnt  <= 4'd0;
        r_gap_next <= w_gap_tgt;
      end else if (r_state == S_GAPWAIT) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end
`ifdef CRTC_CFG_VSYNC_ALIGN_EN
      r_vsync <= vsync;
`endif
    end
  end

endmodule
